// File: rtl/svm_det_collector.sv
// Detection collector behind the SVM classifier: filters windows,
// buffers detections in an FWFT FIFO and tracks per-frame statistics.
module svm_det_collector #(
   parameter int FEA_W = 12,
   parameter int SW_W  = 11,
   parameter int N_SW  = 1200,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_valid,
   input  logic                     is_person,
   input  logic [FEA_W-1:0]         result,
   input  logic [SW_W-1:0]          sw_id,
   input  logic [FEA_W-1:0]         thr,
   input  logic                     o_ready,
   output logic                     o_valid,
   output logic [SW_W-1:0]          o_sw_id,
   output logic [FEA_W-1:0]         o_score,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   output logic                     frame_done,
   output logic [SW_W-1:0]          frame_det,
   output logic                     overflow,
   output logic                     seq_err,
   input  logic                     clr_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [SW_W-1:0] LAST_ID = SW_W'(N_SW - 1);

   typedef enum logic {S_IDLE, S_FRAME} state_t;

   state_t          state_q, state_d;
   logic [SW_W-1:0] exp_q, exp_d;
   logic [SW_W-1:0] run_q;
   logic            start, match, mis, last, qual;
   logic            pop, full, push, drop;

   logic [SW_W+FEA_W-1:0] mem [DEPTH];
   logic [SW_W+FEA_W-1:0] head;
   logic [AW-1:0]         wr_q, rd_q;
   logic [CW-1:0]         cnt_q;

   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      start   = 1'b0;
      match   = 1'b0;
      mis     = 1'b0;
      last    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (i_valid && sw_id == '0) begin
               start   = 1'b1;
               state_d = S_FRAME;
               exp_d   = SW_W'(1);
            end
         end
         S_FRAME: begin
            if (i_valid) begin
               if (sw_id == exp_q) begin
                  match = 1'b1;
                  exp_d = exp_q + 1'b1;
                  if (sw_id == LAST_ID) begin
                     last    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  mis     = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign qual = (start | match) & is_person &
                 ($signed(result) >= $signed(thr));

   assign o_valid  = cnt_q != '0;
   assign pop      = o_valid & o_ready;
   assign full     = cnt_q == CW'(DEPTH);
   // A full FIFO still accepts a push when the head leaves this cycle
   assign push     = qual & (~full | pop);
   assign drop     = qual & full & ~pop;
   assign head     = mem[rd_q];
   assign o_sw_id  = o_valid ? head[SW_W+FEA_W-1:FEA_W] : '0;
   assign o_score  = o_valid ? head[FEA_W-1:0] : '0;
   assign fifo_cnt = cnt_q;

   always_ff @(posedge clk) begin
      if (push) mem[wr_q] <= {sw_id, result};
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         exp_q      <= '0;
         run_q      <= '0;
         frame_done <= 1'b0;
         frame_det  <= '0;
         overflow   <= 1'b0;
         seq_err    <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         exp_q      <= exp_d;
         frame_done <= last;
         if (start)     run_q <= SW_W'(qual);
         else if (last) run_q <= '0;
         else if (qual) run_q <= run_q + 1'b1;
         if (last) frame_det <= run_q + SW_W'(qual);
         overflow <= drop | (overflow & ~clr_err);
         seq_err  <= mis  | (seq_err  & ~clr_err);
         if (push) wr_q <= wr_q + 1'b1;
         if (pop)  rd_q <= rd_q + 1'b1;
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule
